tape_cache_select: RTL

- Parametrised successor to the per-thread select stage: an N-entry tag-matched cache of tape cells between decode and execute.
- Serves cell values to PLUS/MINUS/BRZ instructions and locks cells under modification.
- Fetches misses from shared tape memory; writes back dirty victims (new: write-back eviction, configurable latency, flush).
- Owns its entry state internally instead of passing a packed register-file bus.

---
 rtl/threadbrain_pkg.sv | 31 +++
 rtl/tape_cache_victim.sv | 47 ++++
 rtl/tape_cache_select.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/threadbrain_pkg.sv
// Shared opcode constants, cache entry flags and select-stage FSM states.
package threadbrain_pkg;

    localparam logic [3:0] PLUS  = 4'd1;
    localparam logic [3:0] MINUS = 4'd2;
    localparam logic [3:0] BRZ   = 4'd5;

    typedef struct packed {
        logic valid;
        logic fetching;
        logic locked;
        logic dirty;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVICT,
        ST_READ,
        ST_WAIT,
        ST_FLUSH
    } state_t;

    function automatic logic is_cell_op(input logic [3:0] op);
        return (op == PLUS) || (op == MINUS) || (op == BRZ);
    endfunction

    function automatic logic is_lock_op(input logic [3:0] op);
        return (op == PLUS) || (op == MINUS);
    endfunction

endpackage

// File: rtl/tape_cache_victim.sv
// Victim picker: lowest free entry first, otherwise the next valid unlocked
// entry at or after the round-robin pointer.
module tape_cache_victim #(
    parameter int NENTRIES = 8
) (
    input  logic [NENTRIES-1:0]         valid,
    input  logic [NENTRIES-1:0]         fetching,
    input  logic [NENTRIES-1:0]         locked,
    input  logic [$clog2(NENTRIES)-1:0] rr_ptr,
    output logic [$clog2(NENTRIES)-1:0] idx,
    output logic                        found
);

    localparam int IDX_W = $clog2(NENTRIES);

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] j;

    // Descending loops: the last assignment wins, giving the lowest index
    // (free scan) or the entry closest after rr_ptr (round-robin scan).
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rr_found   = 1'b0;
        rr_idx     = '0;
        j          = '0;
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if (!valid[i] && !fetching[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        for (int k = NENTRIES - 1; k >= 0; k--) begin
            j = rr_ptr + IDX_W'(k);
            if (valid[j] && !locked[j] && !fetching[j]) begin
                rr_found = 1'b1;
                rr_idx   = j;
            end
        end
        found = free_found || rr_found;
        idx   = free_found ? free_idx : rr_idx;
    end

endmodule

// File: rtl/tape_cache_select.sv
// Tag-matched tape cell cache between decode and execute: serves and locks
// cells, fetches misses, writes back dirty victims and flushes on request.
module tape_cache_select #(
    parameter int NENTRIES = 8,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MEM_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        ins_op,
    input  logic [ADDR_W-1:0] ptr,
    input  logic              branch_en,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush_req,
    output logic              stall,
    output logic [DATA_W-1:0] val,
    output logic              val_valid,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_rdata
);

    import threadbrain_pkg::*;

    localparam int IDX_W = $clog2(NENTRIES);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_t                    state, state_nx;
    entry_t [NENTRIES-1:0]     flags;
    logic [ADDR_W-1:0]         tags  [NENTRIES];
    logic [DATA_W-1:0]         datas [NENTRIES];
    logic [IDX_W-1:0]          victim_q, rr_ptr;
    logic [ADDR_W-1:0]         miss_addr_q;
    logic [CNT_W-1:0]          cnt;
    logic                      branch_d1, flush_pend;

    logic [NENTRIES-1:0]       valid_v, fetch_v, lock_v;
    logic [IDX_W-1:0]          vic_idx, hit_idx, wb_idx, fl_idx, lock_idx;
    logic                      vic_found, hit, match_any, wb_hit, fl_found;
    logic                      need, lock_op, branching, in_flight, fill_now;
    logic                      deliver, miss, lock_en, start_miss;

    assign need      = is_cell_op(ins_op);
    assign lock_op   = is_lock_op(ins_op);
    assign branching = branch_en || branch_d1;
    assign in_flight = (state == ST_EVICT) || (state == ST_READ);
    assign fill_now  = (state == ST_WAIT) && (cnt == '0);
    assign deliver   = fill_now && need && !branching && (ptr == miss_addr_q);
    assign miss      = need && !branching && !match_any;

    // The victim of a pending eviction/read still carries its old tag and
    // must look busy so nothing hits or locks it mid-replacement.
    always_comb begin
        match_any = 1'b0;
        hit       = 1'b0;
        hit_idx   = '0;
        wb_hit    = 1'b0;
        wb_idx    = '0;
        fl_found  = 1'b0;
        fl_idx    = '0;
        valid_v   = '0;
        fetch_v   = '0;
        lock_v    = '0;
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            valid_v[i] = flags[i].valid;
            fetch_v[i] = flags[i].fetching;
            lock_v[i]  = flags[i].locked;
            if ((flags[i].valid || flags[i].fetching) && tags[i] == ptr) begin
                match_any = 1'b1;
                if (flags[i].valid && !flags[i].locked && !flags[i].fetching &&
                    !(in_flight && victim_q == IDX_W'(i))) begin
                    hit     = 1'b1;
                    hit_idx = IDX_W'(i);
                end
            end
            if (wb_en && flags[i].valid && flags[i].locked && tags[i] == wb_addr) begin
                wb_hit = 1'b1;
                wb_idx = IDX_W'(i);
            end
            if (flags[i].valid && flags[i].dirty && !flags[i].locked) begin
                fl_found = 1'b1;
                fl_idx   = IDX_W'(i);
            end
        end
    end

    tape_cache_victim #(.NENTRIES(NENTRIES)) u_victim (
        .valid    (valid_v),
        .fetching (fetch_v),
        .locked   (lock_v),
        .rr_ptr   (rr_ptr),
        .idx      (vic_idx),
        .found    (vic_found)
    );

    always_comb begin
        val       = datas[hit_idx];
        val_valid = 1'b0;
        stall     = 1'b0;
        lock_en   = 1'b0;
        lock_idx  = hit_idx;
        if (need && !branching) begin
            if (deliver) begin
                val       = mem_rdata;
                val_valid = 1'b1;
                lock_en   = lock_op;
                lock_idx  = victim_q;
            end else if (hit) begin
                val_valid = 1'b1;
                lock_en   = lock_op;
            end else begin
                stall = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = miss_addr_q;
        mem_wdata  = datas[victim_q];
        flush_done = 1'b0;
        start_miss = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush_pend) begin
                    state_nx = ST_FLUSH;
                end else if (miss && vic_found) begin
                    start_miss = 1'b1;
                    state_nx   = flags[vic_idx].dirty ? ST_EVICT : ST_READ;
                end
            end
            ST_EVICT: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = tags[victim_q];
                if (mem_gnt) state_nx = ST_READ;
            end
            ST_READ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == '0) state_nx = ST_IDLE;
            end
            ST_FLUSH: begin
                if (fl_found) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = tags[fl_idx];
                    mem_wdata = datas[fl_idx];
                end else begin
                    flush_done = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            flags       <= '0;
            victim_q    <= '0;
            rr_ptr      <= '0;
            miss_addr_q <= '0;
            cnt         <= '0;
            branch_d1   <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            state     <= state_nx;
            branch_d1 <= branch_en;
            if (state == ST_IDLE && flush_pend) flush_pend <= 1'b0;
            if (flush_req) flush_pend <= 1'b1;
            if (start_miss) begin
                victim_q    <= vic_idx;
                miss_addr_q <= ptr;
                rr_ptr      <= vic_idx + IDX_W'(1);
            end
            if (state == ST_EVICT && mem_gnt) flags[victim_q].dirty <= 1'b0;
            if (state == ST_READ) begin
                flags[victim_q].valid    <= 1'b0;
                flags[victim_q].fetching <= 1'b1;
            end
            if (state == ST_READ && mem_gnt) cnt <= CNT_W'(MEM_LAT - 1);
            else if (state == ST_WAIT && cnt != '0) cnt <= cnt - CNT_W'(1);
            if (fill_now) begin
                flags[victim_q].valid    <= 1'b1;
                flags[victim_q].fetching <= 1'b0;
            end
            if (lock_en) flags[lock_idx].locked <= 1'b1;
            if (state == ST_FLUSH && fl_found && mem_gnt) flags[fl_idx].dirty <= 1'b0;
            if (wb_hit) begin
                flags[wb_idx].locked <= 1'b0;
                flags[wb_idx].dirty  <= 1'b1;
            end
        end
    end

    // Tags and data are meaningless until the matching valid flag is set.
    always_ff @(posedge clk) begin
        if (state == ST_READ) tags[victim_q] <= miss_addr_q;
        if (fill_now) datas[victim_q] <= mem_rdata;
        if (wb_hit) datas[wb_idx] <= wb_data;
    end

    a_wb_matches: assert property (@(posedge clk) disable iff (!rst_n) wb_en |-> wb_hit);

endmodule
